// File: rtl/muldiv_pkg.sv
// Shared opcodes and state encoding for the multi-cycle MUL/DIV/REMU sequencer.
package muldiv_pkg;

  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_REMU = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    DONE     = 2'd3
  } state_e;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor (or divisor == 0 with rem_in < 2^(WIDTH-1)) always holds in use,
  // so the top bit of the (WIDTH+1)-bit difference is an exact borrow.
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL / DIV / REMU unit: one bit per cycle, stalls the pipe until done.
// Optional MULDIV_EARLY_OUT_EN: zero operands finish in one cycle with the same result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;      // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;      // multiplicand / dividend, becomes quotient
  logic [WIDTH-1:0] opb_q, opb_d;      // multiplier / divisor
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_q),
    .dividend_bit (opa_q[WIDTH-1]),
    .divisor      (opb_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  assign accept = (state_q == IDLE) && start && is_muldiv_op(alu_control) && !kill;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    result_d = result_q;
    stall    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          op_d    = alu_control;
          opa_d   = operand_a;
          opb_d   = operand_b;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = (alu_control == ALU_MUL) ? MUL_ITER : DIV_ITER;
`ifdef MULDIV_EARLY_OUT_EN
          if ((operand_a == '0) || (operand_b == '0)) begin
            state_d = DONE;
            cnt_d   = '0;
            if (alu_control == ALU_MUL)
              result_d = '0;
            else if (operand_b == '0)
              result_d = (alu_control == ALU_DIV) ? '1 : operand_a;
            else
              result_d = '0;
          end
`endif
        end
      end

      MUL_ITER: begin
        stall = 1'b1;
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_q + (opb_q[0] ? opa_q : '0);
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = acc_d;
          end
        end
      end

      DIV_ITER: begin
        stall = 1'b1;
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_rem;
          opa_d = {opa_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = (op_q == ALU_REMU) ? step_rem : opa_d;
          end
        end
      end

      // kill and start are both ignored here; the op completes this cycle
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, checked at done.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .kill        (kill),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (op)
      ALU_MUL: return p[31:0];
      ALU_DIV: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    return (x == 0 || y == 0) ? 1 : 33;
`else
    if (x == y && x != x) return 0;
    return 33;
`endif
  endfunction

  // Accept an op, wait for done, compare result against the scoreboard head.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit start_in_done = 1'b0);
    int          lat;
    bit          seen;
    bit          stall_ok;
    logic [31:0] e;
    exp_q.push_back(model(op, x, y));
    @(negedge clk);
    start = 1'b1; alu_control = op; operand_a = x; operand_b = y; #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL accept_stall op=%0h got %b want 1", op, stall);
    end
    seen = 1'b0; stall_ok = 1'b1; lat = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0; #1;
      if (done === 1'b1) begin
        seen = 1'b1; lat = n;
      end else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL done_timeout op=%0h a=%h b=%h got no done want done", op, x, y);
      return;
    end
    if (result !== e) begin
      errors++; $display("FAIL result op=%0h a=%h b=%h got %h want %h", op, x, y, result, e);
    end
    checks++;
    if (lat != exp_latency(x, y)) begin
      errors++; $display("FAIL latency op=%0h a=%h b=%h got %0d want %0d", op, x, y, lat, exp_latency(x, y));
    end
    checks++;
    if (!stall_ok || stall !== 1'b0) begin
      errors++; $display("FAIL stall_profile op=%0h got iter_ok=%b done_stall=%b want 1/0", op, stall_ok, stall);
    end
    last_exp = e;
    if (start_in_done) begin
      start = 1'b1; alu_control = ALU_MUL; operand_a = 32'd5; operand_b = 32'd5; #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL start_in_done_stall got %b want 0", stall);
      end
      @(negedge clk);
      start = 1'b0; #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL start_in_done_busy got %b want 0", busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; alu_control = 3'b000; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({stall, busy, done} !== 3'b000 || result !== 32'h0) begin
      errors++; $display("FAIL reset_state got s/b/d=%b%b%b res=%h want 000 0", stall, busy, done, result);
    end
    last_exp = 32'h0;
  endtask

  task automatic test_mul_basic();
    run_op(ALU_MUL, 32'd7, 32'd6);
  endtask

  task automatic test_ops();
    logic [2:0]  ops[7] = '{ALU_MUL, ALU_DIV, ALU_REMU, ALU_DIV, ALU_MUL, ALU_REMU, ALU_DIV};
    logic [31:0] as[7]  = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0};
    logic [31:0] bs[7]  = '{32'd2, 32'd7, 32'd7, 32'd3, 32'h9ABC_DEF0, 32'h10, 32'd9};
    for (int i = 0; i < 7; i++) run_op(ops[i], as[i], bs[i]);
  endtask

  task automatic test_div_zero();
    run_op(ALU_DIV, 32'd5, 32'd0);
    run_op(ALU_REMU, 32'd5, 32'd0);
    run_op(ALU_MUL, 32'd0, 32'hABCD_0123);
    run_op(ALU_REMU, 32'd0, 32'd17);
  endtask

  task automatic test_kill();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; alu_control = ALU_DIV; operand_a = 32'd1000; operand_b = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL kill_idle got busy=%b stall=%b want 0 0", busy, stall);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || result !== last_exp) begin
      errors++; $display("FAIL kill_no_done got done_seen=%b res=%h want 0 %h", saw_done, result, last_exp);
    end
    run_op(ALU_MUL, 32'd3, 32'd3);
  endtask

  task automatic test_invalid();
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_control = 3'b000; operand_a = 32'd9; operand_b = 32'd4;
    for (int n = 0; n < 4; n++) begin
      #1; if ({stall, busy, done} !== 3'b000) bad = 1'b1;
      @(negedge clk);
    end
    alu_control = 3'b111;
    #1; if ({stall, busy, done} !== 3'b000) bad = 1'b1;
    @(negedge clk);
    checks++;
    if (bad) begin
      errors++; $display("FAIL invalid_op got activity want stall/busy/done=000");
    end
    bad = 1'b0;
    alu_control = ALU_DIV; kill = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1; if ({stall, busy, done} !== 3'b000) bad = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; kill = 1'b0; #1;
    if ({stall, busy, done} !== 3'b000) bad = 1'b1;
    checks++;
    if (bad || result !== last_exp) begin
      errors++; $display("FAIL kill_priority got bad=%b res=%h want 0 %h", bad, result, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; operand_a = 32'd9; operand_b = 32'd9;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({stall, busy, done} !== 3'b000 || result !== 32'h0) begin
      errors++; $display("FAIL reset_mid got s/b/d=%b%b%b res=%h want 000 0", stall, busy, done, result);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL reset_no_done got done pulse want none");
    end
    last_exp = 32'h0;
    run_op(ALU_MUL, 32'd4, 32'd5);
  endtask

  task automatic test_start_in_done();
    run_op(ALU_DIV, 32'd77, 32'd7, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] x, y;
    for (int i = 0; i < 6; i++) begin
      op = (i % 3 == 0) ? ALU_MUL : (i % 3 == 1) ? ALU_DIV : ALU_REMU;
      x  = $urandom;
      y  = (i == 4) ? 32'd1 : ($urandom >> (i * 4));
      run_op(op, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_ops();
    test_div_zero();
    test_kill();
    test_invalid();
    test_reset_mid();
    test_start_in_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution unit and sequencer for the ALU operations too costly for one cycle: MUL (alu_control 010), DIV (011) and REMU (100).
- Sits beside the single-cycle ALU in the execute stage. Accepts an operation from the decoded alu_control, iterates one bit per cycle and drives a stall to freeze the pipeline until the result is ready.
- Returns the result with a one-cycle done pulse, which the writeback mux selects in place of the ALU result.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count = WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  execute stage presents a valid instruction this cycle.
- alu_control  in  3  decoded ALU op; only 010/011/100 are accepted.
- operand_a  in  WIDTH  multiplicand / dividend.
- operand_b  in  WIDTH  multiplier / divisor.
- kill  in  1  pipeline flush; aborts the in-flight op.
- stall  out  1  freeze PC and upstream pipeline registers.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  WIDTH  product low half / quotient / remainder.

Behaviour:
- Reset: state=IDLE, counter=0, all internal regs=0. Outputs: stall=0, busy=0, done=0, result=0. Reset mid-operation abandons the op with no done pulse.
- States:
  - IDLE.
  - MUL_ITER, DIV_ITER: WIDTH cycles each.
  - DONE: one cycle, then IDLE.
- Accept: in IDLE, start=1 with a valid op and kill=0. Operands are latched at the accepting edge and the counter is loaded with WIDTH.
  - Ops other than 010/011/100, or start outside IDLE, are ignored with no side effects.
- stall: combinational. High in the accept cycle (IDLE & start & valid op & ~kill) and in every ITER cycle. Low in DONE, so the pipeline advances and writes back that same cycle.
- Latency: accept in cycle 0; iterations in cycles 1..WIDTH; DONE with done=1 in cycle WIDTH+1 (33 for WIDTH=32).
- MUL: shift-add.
  - Per cycle: if multiplier LSB=1, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1.
  - Result = low WIDTH bits of the unsigned product; overflow is discarded.
- DIV/REMU: unsigned restoring division, one quotient bit per cycle, MSB first.
  - Per cycle: rem = {rem, dividend MSB}; if rem >= divisor then subtract and set the quotient bit to 1.
  - DIV returns the quotient; REMU returns the remainder.
- Divide by zero: runs the full WIDTH cycles. DIV result = all ones; REMU result = dividend.
- result register updates only on entry to DONE and holds until the next op reaches DONE.
- kill: in any ITER state → IDLE next cycle, stall=0 next cycle, no done, result unchanged. In DONE, kill has no effect; the done pulse still fires. In IDLE, kill has priority over start: nothing is accepted and stall=0.
- start in the DONE cycle is ignored; the instruction it belongs to has already been served.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: if operand_a==0 or operand_b==0 at accept, go straight to DONE in cycle 1 with the architecturally correct result.
  - MUL → 0.
  - DIV x/0 → all ones; REMU x/0 → x.
  - 0/y → quotient 0, remainder 0.
  - stall is high only in cycle 0.
- Undefined: every accepted op takes the full WIDTH+1 cycles. Results are identical either way.

Decomposition:
- Package muldiv_pkg:
  - localparams ALU_MUL=3'b010, ALU_DIV=3'b011, ALU_REMU=3'b100, shared with the decoder and ALU.
  - state enum {IDLE, MUL_ITER, DIV_ITER, DONE}.
- Sub-module div_step: purely combinational single restoring-division step.
  - Inputs: rem_in, next dividend bit, divisor.
  - Outputs: rem_out, q_bit.
  - Instantiated once, used every DIV_ITER cycle.

Test Plan:
- MUL 7×6, WIDTH=32 → stall high cycles 0..32; done=1 only in cycle 33; result=42.
- MUL 0xFFFFFFFF×2 → result=0xFFFFFFFE; DIV 100/7 → 14; REMU 100/7 → 2; DIV 0x80000000/3 → 0x2AAAAAAA.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; latency 33 without the macro, 1 with MULDIV_EARLY_OUT_EN.
- Kill asserted in cycle 10 of a DIV → busy=0 and stall=0 in cycle 11; no done; result keeps its prior value. Next MUL 3×3 → 9.
- Assert start with alu_control=000, and start with a valid op while kill=1 → stall, busy and done stay 0 throughout.
- Assert rst in cycle 5 of a MUL → next cycle all outputs 0, state=IDLE, no done. A following start is accepted normally.
